// File: rtl/mac_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mac_adder_arbiter
// Purpose : Round-robin share of one 4-lane split-mode (32b / 2x16b) adder
//           with a single registered result. Optional burst lock under
//           `define MAC_ARB_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mac_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_mode,
  input  logic [NREQ*128-1:0] req_x,
  input  logic [NREQ*128-1:0] req_y,
  input  logic [NREQ-1:0]     req_lock,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_sum,
  output logic [IDW-1:0]      out_id,
  output logic                out_mode
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FULL   = 2'd1,
    S_STALL  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [127:0]    r_sum;
  logic [IDW-1:0]  r_id;
  logic            r_mode;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_rr_nxt;

  logic            w_valid;
  logic            w_valid_nxt;
  logic            w_can_accept;
  logic            w_found;
  logic            w_fire;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [127:0]    w_x;
  logic [127:0]    w_y;
  logic [127:0]    w_sum;
  logic            w_mode;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // Every state except IDLE holds a result (LOCKED with nothing held falls to IDLE).
  assign w_valid      = (r_state != S_IDLE);
  assign w_can_accept = !w_valid || out_ready;

`ifdef MAC_ARB_LOCK_EN
  logic           r_locked;
  logic [IDW-1:0] r_owner;
  logic           w_locked_nxt;
  logic [IDW-1:0] w_owner_nxt;

  always_comb begin
    w_elig = req_valid;
    if (r_locked) begin
      w_elig          = '0;
      w_elig[r_owner] = req_valid[r_owner];
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;
  assign w_elig        = req_valid;
`endif

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_elig[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    if (w_found && w_can_accept) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_fire    = |w_grant;
  assign req_ready = rst ? '0 : w_grant;

  assign w_x    = req_x[128*w_gnt_idx +: 128];
  assign w_y    = req_y[128*w_gnt_idx +: 128];
  assign w_mode = req_mode[w_gnt_idx];

  // In 16-bit mode the carry out of bit 15 is simply not forwarded.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [15:0] lo;
    logic [15:0] hi;
    logic        c16;
    assign {c16, lo} = {1'b0, w_x[32*l +: 16]} + {1'b0, w_y[32*l +: 16]};
    assign hi        = w_x[32*l+16 +: 16] + w_y[32*l+16 +: 16] + {15'd0, w_mode & c16};
    assign w_sum[32*l +: 32] = {hi, lo};
  end

`ifdef MAC_ARB_LOCK_EN
  always_comb begin
    w_locked_nxt = r_locked;
    w_owner_nxt  = r_owner;
    w_rr_nxt     = r_rr_ptr;
    if (r_locked) begin
      if (!req_valid[r_owner] || (w_fire && !req_lock[r_owner])) begin
        w_locked_nxt = 1'b0;
        w_rr_nxt     = rr_next(r_owner);
      end
    end else if (w_fire) begin
      w_rr_nxt = rr_next(w_gnt_idx);
      if (req_lock[w_gnt_idx]) begin
        w_locked_nxt = 1'b1;
        w_owner_nxt  = w_gnt_idx;
      end
    end
  end
`else
  assign w_rr_nxt = w_fire ? rr_next(w_gnt_idx) : r_rr_ptr;
`endif

  assign w_valid_nxt = w_fire || (w_valid && !out_ready);

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_valid_nxt) begin
      w_state_nxt = (w_valid && !out_ready) ? S_STALL : S_FULL;
`ifdef MAC_ARB_LOCK_EN
      if (w_locked_nxt) begin
        w_state_nxt = S_LOCKED;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sum    <= '0;
      r_id     <= '0;
      r_mode   <= 1'b0;
      r_rr_ptr <= '0;
`ifdef MAC_ARB_LOCK_EN
      r_locked <= 1'b0;
      r_owner  <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      if (w_fire) begin
        r_sum  <= w_sum;
        r_id   <= w_gnt_idx;
        r_mode <= w_mode;
      end
`ifdef MAC_ARB_LOCK_EN
      r_locked <= w_locked_nxt;
      r_owner  <= w_owner_nxt;
`endif
    end
  end

  assign out_valid = w_valid;
  assign out_sum   = r_sum;
  assign out_id    = r_id;
  assign out_mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_mac_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_adder_arbiter
// Purpose : Directed scoreboard bench for mac_adder_arbiter (NREQ=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic         lock;
    logic         mode;
    logic [127:0] x;
    logic [127:0] y;
  } item_t;

  typedef struct packed {
    logic [1:0]   id;
    logic         mode;
    logic [127:0] sum;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_mode = '0;
  logic [NREQ*128-1:0] req_x = '0;
  logic [NREQ*128-1:0] req_y = '0;
  logic [NREQ-1:0]     req_lock = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [127:0]        out_sum;
  logic [IDW-1:0]      out_id;
  logic                out_mode;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  exp_q[$];
  item_t items[NREQ][32];
  int    hd[NREQ];
  int    tl[NREQ];
  logic [NREQ-1:0] fired = '0;

  mac_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_x(req_x), .req_y(req_y), .req_lock(req_lock),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] model_sum(input logic m, input logic [127:0] x, input logic [127:0] y);
    logic [127:0] s;
    logic [31:0]  a;
    logic [31:0]  b;
    s = '0;
    for (int l = 0; l < 4; l++) begin
      a = x[32*l +: 32];
      b = y[32*l +: 32];
      if (m) s[32*l +: 32] = a + b;
      else   s[32*l +: 32] = {a[31:16] + b[31:16], a[15:0] + b[15:0]};
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add_req(input int i, input logic m, input logic [127:0] x, input logic [127:0] y, input logic lk);
    items[i][tl[i]] = {lk, m, x, y};
    tl[i]++;
  endtask

  task automatic add_exp(input int id, input logic m, input logic [127:0] s);
    exp_q.push_back({2'(id), m, s});
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Requester model: present queue heads, retire items that were accepted.
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (fired[i]) hd[i]++;
    for (int i = 0; i < NREQ; i++) begin
      if (hd[i] != tl[i]) begin
        req_valid[i]          = 1'b1;
        req_lock[i]           = items[i][hd[i]].lock;
        req_mode[i]           = items[i][hd[i]].mode;
        req_x[128*i +: 128]   = items[i][hd[i]].x;
        req_y[128*i +: 128]   = items[i][hd[i]].y;
      end else begin
        req_valid[i] = 1'b0;
        req_lock[i]  = 1'b0;
      end
    end
    #1;
    fired = req_valid & req_ready;
  end

  // Monitor: every accepted result is compared with the scoreboard head.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL result_unexpected: got id=%0d sum=%h, expected no result", out_id, out_sum);
      end else begin
        e = exp_q.pop_front();
        if ({out_id, out_mode, out_sum} !== {e.id, e.mode, e.sum}) begin
          n_errors++;
          $display("FAIL result: got id=%0d mode=%0d sum=%h, expected id=%0d mode=%0d sum=%h",
                   out_id, out_mode, out_sum, e.id, e.mode, e.sum);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_sum",   out_sum,         128'd0);
    chk("rst_out_id",    128'(out_id),    128'd0);
    chk("rst_out_mode",  128'(out_mode),  128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single 32-bit request, one-cycle latency
    @(negedge clk);
    add_req(0, 1'b1, {32'h0000_0005, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF},
                     {32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0002, 32'h0000_0001}, 1'b0);
    add_exp(0, 1'b1, {32'h0000_0004, 32'h2345_6789, 32'h0000_0003, 32'h0000_0000});
    @(negedge clk);
    #3;
    chk("lat_out_valid", 128'(out_valid), 128'd1);
    chk("lat_out_id",    128'(out_id),    128'd0);
    chk("lat_out_mode",  128'(out_mode),  128'd1);
    drain();

    // 16-bit carry cut versus 32-bit carry
    @(negedge clk);
    add_req(1, 1'b0, {96'd0, 32'h0000_FFFF}, {96'd0, 32'h0000_0001}, 1'b0);
    add_req(2, 1'b1, {96'd0, 32'h0000_FFFF}, {96'd0, 32'h0000_0001}, 1'b0);
    add_req(3, 1'b0, {32'hFFFF_0000, 32'h8001_8001, 64'd0}, {32'h0001_0000, 32'h8000_8000, 64'd0}, 1'b0);
    add_exp(1, 1'b0, 128'h0);
    add_exp(2, 1'b1, {96'd0, 32'h0001_0000});
    add_exp(3, 1'b0, {32'h0000_0000, 32'h0001_0001, 64'd0});
    drain();

    // All four valid, back-to-back round robin with no bubbles
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        x = {32'h89AB_CDEF ^ 32'(i), 32'hFFFF_FFFF, 32'h0000_8000 + 32'(k), 32'h7FFF_FFFF - 32'(i)};
        y = {32'h7654_3210, 32'h0000_0001 + 32'(k), 32'h0000_8000, 32'h0001_0001 * 32'(i + 1)};
        add_req(i, 1'((i + k) % 2), x, y, 1'b0);
        add_exp(i, 1'((i + k) % 2), model_sum(1'((i + k) % 2), x, y));
      end
    end
    @(negedge clk);
    #3;
    for (int n = 0; n < 8; n++) begin
      chk("stream_no_bubble", 128'(out_valid), 128'd1);
      @(negedge clk);
      #3;
    end
    drain();

    // Stall: held result stays stable and no grant is issued
    @(negedge clk);
    out_ready = 1'b0;
    add_req(0, 1'b1, {4{32'hDEAD_BEEF}}, {4{32'h0000_0011}}, 1'b0);
    add_req(1, 1'b0, {4{32'h1234_FFFF}}, {4{32'h0001_0001}}, 1'b0);
    add_req(2, 1'b1, {4{32'h0000_0001}}, {4{32'h0000_0002}}, 1'b0);
    add_exp(0, 1'b1, {4{32'hDEAD_BF00}});
    add_exp(1, 1'b0, {4{32'h1235_0000}});
    add_exp(2, 1'b1, {4{32'h0000_0003}});
    @(negedge clk);
    #3;
    for (int n = 0; n < 3; n++) begin
      chk("stall_out_valid", 128'(out_valid), 128'd1);
      chk("stall_out_id",    128'(out_id),    128'd0);
      chk("stall_out_sum",   out_sum,         {4{32'hDEAD_BF00}});
      chk("stall_req_ready", 128'(req_ready), 128'd0);
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Reset during stall with requesters waiting
    @(negedge clk);
    out_ready = 1'b0;
    add_req(2, 1'b1, {4{32'h0000_00A0}}, {4{32'h0000_000A}}, 1'b0);
    add_req(2, 1'b1, {4{32'h0000_0B00}}, {4{32'h0000_00B0}}, 1'b0);
    add_exp(2, 1'b1, {4{32'h0000_00AA}});
    @(negedge clk);
    add_req(3, 1'b0, {4{32'h0C00_0C00}}, {4{32'h00C0_00C0}}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_req_ready", 128'(req_ready), 128'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    add_exp(2, 1'b1, {4{32'h0000_0BB0}});
    add_exp(3, 1'b0, {4{32'h0CC0_0CC0}});
    drain();

    // Move round-robin pointer to requester 1, then burst lock from requester 1
    @(negedge clk);
    add_req(0, 1'b1, {4{32'h0000_0001}}, {4{32'h0000_0001}}, 1'b0);
    add_exp(0, 1'b1, {4{32'h0000_0002}});
    drain();
    @(negedge clk);
    add_req(1, 1'b1, {4{32'h0000_0010}}, {4{32'h0000_0001}}, 1'b1);
    add_req(1, 1'b1, {4{32'h0000_0020}}, {4{32'h0000_0002}}, 1'b1);
    add_req(1, 1'b1, {4{32'h0000_0030}}, {4{32'h0000_0003}}, 1'b0);
    add_req(0, 1'b1, {4{32'h0000_0100}}, {4{32'h0000_0000}}, 1'b0);
    add_req(2, 1'b1, {4{32'h0000_0200}}, {4{32'h0000_0000}}, 1'b0);
    add_req(3, 1'b1, {4{32'h0000_0300}}, {4{32'h0000_0000}}, 1'b0);
`ifdef MAC_ARB_LOCK_EN
    add_exp(1, 1'b1, {4{32'h0000_0011}});
    add_exp(1, 1'b1, {4{32'h0000_0022}});
    add_exp(1, 1'b1, {4{32'h0000_0033}});
    add_exp(2, 1'b1, {4{32'h0000_0200}});
    add_exp(3, 1'b1, {4{32'h0000_0300}});
    add_exp(0, 1'b1, {4{32'h0000_0100}});
`else
    add_exp(1, 1'b1, {4{32'h0000_0011}});
    add_exp(2, 1'b1, {4{32'h0000_0200}});
    add_exp(3, 1'b1, {4{32'h0000_0300}});
    add_exp(0, 1'b1, {4{32'h0000_0100}});
    add_exp(1, 1'b1, {4{32'h0000_0022}});
    add_exp(1, 1'b1, {4{32'h0000_0033}});
`endif
    drain();

    @(negedge clk);
    @(negedge clk);
    chk("final_idle", 128'(out_valid), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
